// File: rtl/serial_sig_pkg.sv
// Shared types and default CRC constants for the serial signature checker.
package serial_sig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } sig_state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

endpackage

// File: rtl/sig_lfsr_step.sv
// One-bit serial CRC update: shift left, fold in POLY when MSB xor input is set.
module sig_lfsr_step
    import serial_sig_pkg::*;
#(
    parameter int unsigned           SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0]  POLY      = SIG_WIDTH'(DEFAULT_POLY)
) (
    input  logic [SIG_WIDTH-1:0] sig_in,
    input  logic                 bit_in,
    output logic [SIG_WIDTH-1:0] sig_next_c
);

    logic fb_c;

    always_comb begin
        fb_c       = sig_in[SIG_WIDTH-1] ^ bit_in;
        sig_next_c = {sig_in[SIG_WIDTH-2:0], 1'b0} ^ (fb_c ? POLY : '0);
    end

endmodule

// File: rtl/serial_sig_checker.sv
// Compacts a window of serial test data into a CRC signature after a flush
// period and compares it against a golden value.
module serial_sig_checker
    import serial_sig_pkg::*;
#(
    parameter int unsigned           SIG_WIDTH    = 16,
    parameter logic [SIG_WIDTH-1:0]  POLY         = SIG_WIDTH'(DEFAULT_POLY),
    parameter logic [SIG_WIDTH-1:0]  SEED         = SIG_WIDTH'(DEFAULT_SEED),
    parameter int unsigned           FLUSH_CYCLES = 10,
    parameter int unsigned           WINDOW       = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              bit_in,
    input  logic [SIG_WIDTH-1:0]              expected,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [SIG_WIDTH-1:0]              signature,
    output logic [$clog2(WINDOW+1)-1:0]       bit_count
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);
    localparam int unsigned FLS_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    sig_state_e             state, state_nxt;
    logic [FLS_W-1:0]       flush_cnt, flush_nxt;
    logic [SIG_WIDTH-1:0]   sig_nxt, sig_step_c;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   pass_nxt, busy_nxt, done_nxt;

    sig_lfsr_step #(
        .SIG_WIDTH (SIG_WIDTH),
        .POLY      (POLY)
    ) u_step (
        .sig_in     (signature),
        .bit_in     (bit_in),
        .sig_next_c (sig_step_c)
    );

    // Next-state and next-output logic; abort overrides everything else.
    always_comb begin
        state_nxt = state;
        flush_nxt = flush_cnt;
        sig_nxt   = signature;
        cnt_nxt   = bit_count;
        pass_nxt  = pass;

        if (abort) begin
            state_nxt = IDLE;
            pass_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = (FLUSH_CYCLES == 0) ? CAPTURE : FLUSH;
                        flush_nxt = '0;
                        sig_nxt   = SEED;
                        cnt_nxt   = '0;
                        pass_nxt  = 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLS_W'(FLUSH_CYCLES - 1)) begin
                        state_nxt = CAPTURE;
                    end else begin
                        flush_nxt = flush_cnt + FLS_W'(1);
                    end
                end
                CAPTURE: begin
                    sig_nxt = sig_step_c;
                    if (bit_count < CNT_W'(WINDOW)) begin
                        cnt_nxt = bit_count + CNT_W'(1);
                    end
                    if (bit_count == CNT_W'(WINDOW - 1)) begin
                        state_nxt = DONE;
                        pass_nxt  = (sig_step_c == expected);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt == FLUSH) || (state_nxt == CAPTURE);
        done_nxt = (state_nxt == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            signature <= SEED;
            bit_count <= '0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            signature <= sig_nxt;
            bit_count <= cnt_nxt;
            pass      <= pass_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
